// File: rtl/imm_gen_if.sv
// imm_gen_if: decode-side bundle for imm_gen; master drives instr/imm_sel/en, slave returns imm_out/sel_err/imm_q/imm_valid
interface imm_gen_if;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic        en;
  logic [31:0] imm_out;
  logic        sel_err;
  logic [31:0] imm_q;
  logic        imm_valid;
  modport master (output instr, imm_sel, en, input imm_out, sel_err, imm_q, imm_valid);
  modport slave  (input instr, imm_sel, en, output imm_out, sel_err, imm_q, imm_valid);
endinterface

// File: rtl/imm_gen.sv
// imm_gen: RV32I I/S/B/U/J immediate extract+sign-extend; ports clk, rst_n (async low), b (imm_gen_if.slave: instr, imm_sel, en -> imm_out, sel_err, imm_q, imm_valid)
module imm_gen (
  input logic       clk,
  input logic       rst_n,
  imm_gen_if.slave  b
);
  logic [31:0] ins, imm, imm_d, imm_q;
  logic        err, valid_d, valid_q;
  logic        unused_opcode;
  assign ins = b.instr;
  assign unused_opcode = ^ins[6:0];
  always_comb begin
    err = b.imm_sel > 3'd4;
    imm = b.imm_sel == 3'd0 ? {{20{ins[31]}}, ins[31:20]} :
          b.imm_sel == 3'd1 ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
          b.imm_sel == 3'd2 ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
          b.imm_sel == 3'd3 ? {ins[31:12], 12'b0} :
          b.imm_sel == 3'd4 ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} :
                              32'd0;
    imm_d   = b.en ? imm : imm_q;
    valid_d = b.en & ~err;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  assign b.imm_out   = imm;
  assign b.sel_err   = err;
  assign b.imm_q     = imm_q;
  assign b.imm_valid = valid_q;
endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: directed self-checking bench for imm_gen
module tb_imm_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vecs = 0;
  int errs = 0;
  imm_gen_if bus();
  imm_gen dut (.clk(clk), .rst_n(rst_n), .b(bus.slave));
  always #5 clk = ~clk;

  task automatic comb_chk(input string nm, input logic [2:0] sel, input logic [31:0] ins, input logic [31:0] ex);
    bus.imm_sel = sel;
    bus.instr   = ins;
    #1;
    vecs++;
    if (bus.imm_out !== ex || bus.sel_err !== 1'b0) begin
      errs++;
      $display("FAIL %s instr=%h: imm_out=%h sel_err=%b, required %h / 0", nm, ins, bus.imm_out, bus.sel_err, ex);
    end
  endtask

  task automatic test_reset();
    bus.en = 1'b1; bus.imm_sel = 3'd0; bus.instr = 32'h7FF00000;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (bus.imm_q !== 32'd0 || bus.imm_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: imm_q=%h imm_valid=%b, required 0/0", bus.imm_q, bus.imm_valid);
    end
    vecs++;
    if (bus.imm_out !== 32'h000007FF) begin
      errs++;
      $display("FAIL comb_in_reset: imm_out=%h, required 000007FF", bus.imm_out);
    end
    @(negedge clk);
    bus.en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_i_type();
    comb_chk("i_pos",  3'd0, 32'h7FF00000, 32'h000007FF);
    comb_chk("i_neg",  3'd0, 32'h80000000, 32'hFFFFF800);
    comb_chk("i_mid",  3'd0, 32'h12300000, 32'h00000123);
    comb_chk("i_opc",  3'd0, 32'h7FF0007F, 32'h000007FF);
  endtask

  task automatic test_s_type();
    comb_chk("s_pos", 3'd1, 32'h0000A223, 32'h00000004);
    comb_chk("s_neg", 3'd1, 32'hFE002423, 32'hFFFFFFE8);
  endtask

  task automatic test_b_type();
    comb_chk("b_pos", 3'd2, 32'h04000063, 32'h00000040);
    comb_chk("b_neg", 3'd2, 32'hFE0000E3, 32'hFFFFFFE0);
    comb_chk("b_all", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
  endtask

  task automatic test_u_type();
    comb_chk("u_pos", 3'd3, 32'h12345000, 32'h12345000);
    comb_chk("u_neg", 3'd3, 32'hFFFFF000, 32'hFFFFF000);
    comb_chk("u_low", 3'd3, 32'h00000FFF, 32'h00000000);
  endtask

  task automatic test_j_type();
    comb_chk("j_pos", 3'd4, 32'h004000EF, 32'h00000004);
    comb_chk("j_neg", 3'd4, 32'h801FF06F, 32'hFFFFF800);
    comb_chk("j_all", 3'd4, 32'hFFFFFFFF, 32'hFFFFFFFE);
  endtask

  task automatic test_reserved();
    for (int s = 5; s < 8; s++) begin
      bus.imm_sel = 3'(s);
      bus.instr   = 32'hFFFFFFFF;
      #1;
      vecs++;
      if (bus.imm_out !== 32'd0 || bus.sel_err !== 1'b1) begin
        errs++;
        $display("FAIL reserved_%0d: imm_out=%h sel_err=%b, required 0 / 1", s, bus.imm_out, bus.sel_err);
      end
    end
    @(negedge clk);
    bus.en = 1'b1; bus.imm_sel = 3'd0; bus.instr = 32'h7FF00000;
    @(negedge clk);
    bus.imm_sel = 3'd6; bus.instr = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    vecs++;
    if (bus.imm_q !== 32'd0 || bus.imm_valid !== 1'b0) begin
      errs++;
      $display("FAIL reserved_capture: imm_q=%h imm_valid=%b, required 0/0", bus.imm_q, bus.imm_valid);
    end
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  task automatic test_registered();
    @(negedge clk);
    bus.en = 1'b1; bus.imm_sel = 3'd0; bus.instr = 32'h7FF00000;
    @(posedge clk);
    #1;
    vecs++;
    if (bus.imm_q !== 32'h000007FF || bus.imm_valid !== 1'b1) begin
      errs++;
      $display("FAIL reg_capture: imm_q=%h imm_valid=%b, required 000007FF/1", bus.imm_q, bus.imm_valid);
    end
    @(negedge clk);
    bus.en = 1'b0; bus.instr = 32'h12300000;
    @(posedge clk);
    #1;
    vecs++;
    if (bus.imm_q !== 32'h000007FF || bus.imm_valid !== 1'b0 || bus.imm_out !== 32'h00000123) begin
      errs++;
      $display("FAIL reg_hold: imm_q=%h imm_valid=%b imm_out=%h, required 000007FF/0/00000123", bus.imm_q, bus.imm_valid, bus.imm_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  sels[3] = '{3'd3, 3'd4, 3'd1};
    logic [31:0] ins[3]  = '{32'h12345000, 32'h801FF06F, 32'hFE002423};
    logic [31:0] exs[3]  = '{32'h12345000, 32'hFFFFF800, 32'hFFFFFFE8};
    @(negedge clk);
    bus.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.imm_sel = sels[k];
      bus.instr   = ins[k];
      @(posedge clk);
      #1;
      vecs++;
      if (bus.imm_q !== exs[k] || bus.imm_valid !== 1'b1) begin
        errs++;
        $display("FAIL b2b_%0d: imm_q=%h imm_valid=%b, required %h/1", k, bus.imm_q, bus.imm_valid, exs[k]);
      end
      @(negedge clk);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.en = 1'b1; bus.imm_sel = 3'd3; bus.instr = 32'hFFFFF000;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (bus.imm_q !== 32'd0 || bus.imm_valid !== 1'b0) begin
      errs++;
      $display("FAIL async_clear: imm_q=%h imm_valid=%b, required 0/0", bus.imm_q, bus.imm_valid);
    end
    vecs++;
    if (bus.imm_out !== 32'hFFFFF000) begin
      errs++;
      $display("FAIL comb_during_reset: imm_out=%h, required FFFFF000", bus.imm_out);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (bus.imm_q !== 32'd0 || bus.imm_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_hold: imm_q=%h imm_valid=%b, required 0/0", bus.imm_q, bus.imm_valid);
    end
    @(negedge clk);
    bus.en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vecs++;
    if (bus.imm_q !== 32'd0 || bus.imm_valid !== 1'b0) begin
      errs++;
      $display("FAIL post_release_idle: imm_q=%h imm_valid=%b, required 0/0", bus.imm_q, bus.imm_valid);
    end
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    vecs++;
    if (bus.imm_q !== 32'hFFFFF000 || bus.imm_valid !== 1'b1) begin
      errs++;
      $display("FAIL first_capture: imm_q=%h imm_valid=%b, required FFFFF000/1", bus.imm_q, bus.imm_valid);
    end
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_s_type();
    test_b_type();
    test_u_type();
    test_j_type();
    test_reserved();
    test_registered();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/imm_gen.md
# imm_gen

Immediate generator for the RV32I decode stage. It extracts and sign-extends the I, S, B, U or J immediate from a 32-bit instruction word, selected by a 3-bit code from the control decoder. The combinational result `imm_out` feeds the ALU operand mux and the branch/jump target adder in the same cycle. A registered copy with a valid flag feeds the pipelined execute stage.

## Interface
- No parameters; data width is fixed at 32 bits.
- `clk`  input  1  system clock; all registers update on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `instr`  input  32  instruction word.
- `imm_sel`  input  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J; 101–111 reserved.
- `en`  input  1  capture strobe for the registered stage.
- `imm_out`  output  32  combinational sign-extended immediate.
- `sel_err`  output  1  combinational; high when `imm_sel` is reserved.
- `imm_q`  output  32  registered immediate.
- `imm_valid`  output  1  registered; high for the cycle after a capture.

## Operation
- Immediates are assembled from `instr` (bit 31 is the sign bit in every format):
  - I (000): `imm_out = {{20{instr[31]}}, instr[31:20]}`.
  - S (001): `{{20{instr[31]}}, instr[31:25], instr[11:7]}`.
  - B (010): `{{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}`. Bit 0 is always 0.
  - U (011): `{instr[31:12], 12'b0}`. There is no sign extension beyond bit 31.
  - J (100): `{{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}`. Bit 0 is always 0.
- Reserved `imm_sel` (101, 110, 111): `imm_out = 0` and `sel_err = 1`. Otherwise `sel_err = 0`.
- `imm_out` and `sel_err` depend only on `instr` and `imm_sel`. They do not depend on `clk`, `rst_n` or `en`, and contain no latches.
- Opcode bits `instr[6:0]` are ignored; the format comes solely from `imm_sel`.
- Registered stage, on each rising edge of `clk` with `rst_n` high:
  - `en = 1`: `imm_q <= imm_out`; `imm_valid <= ~sel_err`.
  - `en = 0`: `imm_q` holds its value; `imm_valid <= 0`.
- A reserved selector with `en = 1` loads `imm_q` with 0 and drives `imm_valid` to 0.

## Timing
- `imm_out` and `sel_err` have zero-cycle latency and settle within the combinational path after any input change.
- `imm_q` and `imm_valid` have one-cycle latency: they reflect the inputs sampled at the capturing edge.
- Reset: asserting `rst_n` low immediately forces `imm_q = 0` and `imm_valid = 0`, independent of `clk`, including mid-capture. Combinational outputs are unaffected by reset.
- The first capture occurs on the first rising edge after `rst_n` deasserts with `en = 1`.
- Back-to-back `en` pulses capture on every cycle; `imm_valid` stays high continuously while valid selectors are presented.
- No handshake or backpressure: the consumer must take `imm_q` in the cycle `imm_valid` is high.

## Test plan
- I-type: `instr` 0x7FF00000 → 0x000007FF; 0x80000000 → 0xFFFFF800; 0x12300000 → 0x00000123.
- S-type: 0x0000A223 → 0x00000004; 0xFE002423 → 0xFFFFFFE8. B-type: 0x04000063 → 0x00000040; 0xFE0000E3 → 0xFFFFFFE0.
- U-type: 0x12345000 → 0x12345000; 0xFFFFF000 → 0xFFFFF000. J-type: 0x004000EF → 0x00000004; 0x801FF06F → 0xFFFFF800.
- Reserved `imm_sel` 101/110/111 with `instr` 0xFFFFFFFF → `imm_out` 0 and `sel_err` 1. Capturing it with `en = 1` gives `imm_q` 0 and `imm_valid` 0.
- Registered path: `en = 1` with I 0x7FF00000 → next cycle `imm_q` 0x000007FF and `imm_valid` 1. Then `en = 0` with a new `instr` → `imm_q` holds and `imm_valid` drops to 0.
- Reset: pull `rst_n` low between clock edges while `imm_q` is nonzero → `imm_q` and `imm_valid` clear immediately. They remain 0 until the first `en = 1` edge after release.
